// File: rtl/nand_cpu_pkg.sv
// Shared processor types: memory-side sizing, cache request codes and the
// memory-arbiter ownership/state encodings.
package nand_cpu_pkg;

    localparam int CACHE_BLOCK_SIZE = 64;
    localparam int MEM_TRANS_SIZE   = 16;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } CacheRequest;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } MemOwner;

    // Arbiter-local names, kept apart from the cache controller states.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CMD   = 2'd1,
        ARB_BURST = 2'd2
    } ArbState;

endpackage

// File: rtl/d_cache_request_ifc.sv
// Block request channel between a cache and the memory side; the memory
// modport is what the arbiter presents to each cache.
interface d_cache_request_ifc #(
    parameter int ADDR_BITS = 16 - $clog2(nand_cpu_pkg::CACHE_BLOCK_SIZE),
    parameter int DATA_BITS = nand_cpu_pkg::MEM_TRANS_SIZE
);
    nand_cpu_pkg::CacheRequest req;
    logic [ADDR_BITS-1:0]      address;
    logic [DATA_BITS-1:0]      w_data;
    logic [DATA_BITS-1:0]      r_data;
    logic                      ack;

    modport memory (input req, address, w_data, output ack, r_data);
    modport cache  (output req, address, w_data, input ack, r_data);
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side
// that did not hold the previous grant.
module rr_pick2
    import nand_cpu_pkg::*;
(
    input  logic    i_req_i,
    input  logic    d_req_i,
    input  MemOwner last_grant_i,
    output logic    valid_o,
    output MemOwner winner_o
);
    always_comb begin
        valid_o  = i_req_i | d_req_i;
        winner_o = OWNER_I;
        if (i_req_i && d_req_i) begin
            winner_o = (last_grant_i == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (d_req_i) begin
            winner_o = OWNER_D;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the backing-memory port between the i-cache and d-cache channels:
// round-robin grant, command forwarding and burst data steering.
module mem_arbiter
    import nand_cpu_pkg::*;
#(
    parameter int ADDR_BITS = 16 - $clog2(CACHE_BLOCK_SIZE),
    parameter int BEATS     = CACHE_BLOCK_SIZE / MEM_TRANS_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    d_cache_request_ifc.memory        i_port,
    d_cache_request_ifc.memory        d_port,
    output CacheRequest               mem_req,
    output logic [ADDR_BITS-1:0]      mem_address,
    input  logic                      mem_ack,
    input  logic [MEM_TRANS_SIZE-1:0] mem_r_data,
    output logic [MEM_TRANS_SIZE-1:0] mem_w_data,
    output logic                      busy
);
    localparam int                   BEAT_BITS = $clog2(BEATS);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    ArbState              state_q,      state_d;
    logic [BEAT_BITS-1:0] beat_q,       beat_d;
    MemOwner              last_grant_q, last_grant_d;
    MemOwner              owner_q,      owner_d;
    CacheRequest          op_q,         op_d;
    logic [ADDR_BITS-1:0] addr_q,       addr_d;

    logic    i_active, d_active;
    logic    pick_valid;
    MemOwner pick_winner;

    // The i-cache never writes back, so a stray REQ_WRITE there is ignored.
    assign i_active = (i_port.req == REQ_READ);
    assign d_active = (d_port.req != REQ_NONE);

    rr_pick2 u_pick (
        .i_req_i      (i_active),
        .d_req_i      (d_active),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    // Handshake: mem_req is a command valid held stable until mem_ack (the
    // ready) is seen in the same cycle; beats then follow one per cycle with
    // no backpressure in either direction.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        addr_d       = addr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    op_d    = (pick_winner == OWNER_D) ? d_port.req : REQ_READ;
                    addr_d  = (pick_winner == OWNER_D) ? d_port.address : i_port.address;
                    state_d = ARB_CMD;
                end
            end
            ARB_CMD: begin
                if (mem_ack) begin
                    beat_d  = '0;
                    state_d = ARB_BURST;
                end
            end
            ARB_BURST: begin
                beat_d = beat_q + BEAT_BITS'(1);
                if (beat_q == LAST_BEAT) begin
                    last_grant_d = owner_q;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            beat_q       <= '0;
            last_grant_q <= OWNER_I;
            owner_q      <= OWNER_I;
            op_q         <= REQ_NONE;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
        end
    end

    logic                      in_cmd, in_burst;
    logic                      owner_ack;
    logic                      rd_burst, wr_burst;
    logic [MEM_TRANS_SIZE-1:0] owner_r_data;

    assign in_cmd   = (state_q == ARB_CMD);
    assign in_burst = (state_q == ARB_BURST);
    assign rd_burst = in_burst && (op_q == REQ_READ);
    assign wr_burst = in_burst && (op_q == REQ_WRITE);

    assign mem_req      = in_cmd ? op_q : REQ_NONE;
    assign mem_address  = in_cmd ? addr_q : '0;
    assign owner_ack    = in_cmd & mem_ack;
    assign owner_r_data = rd_burst ? mem_r_data : '0;
    assign mem_w_data   = !wr_burst ? '0 :
                          (owner_q == OWNER_D) ? d_port.w_data : i_port.w_data;
    assign busy         = (state_q != ARB_IDLE);

    // Non-owner outputs are forced to zero so a cache never sees foreign traffic.
    assign i_port.ack    = owner_ack && (owner_q == OWNER_I);
    assign d_port.ack    = owner_ack && (owner_q == OWNER_D);
    assign i_port.r_data = (owner_q == OWNER_I) ? owner_r_data : '0;
    assign d_port.r_data = (owner_q == OWNER_D) ? owner_r_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized request mixes
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;
    import nand_cpu_pkg::*;

    localparam int BEATS = 4;
    localparam int AW    = 10;
    localparam int DW    = 16;

    logic           clk = 1'b0;
    logic           rst;
    CacheRequest    mem_req;
    logic [AW-1:0]  mem_address;
    logic           mem_ack;
    logic [DW-1:0]  mem_r_data;
    logic [DW-1:0]  mem_w_data;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    d_cache_request_ifc i_if ();
    d_cache_request_ifc d_if ();

    mem_arbiter #(.ADDR_BITS(AW), .BEATS(BEATS)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_port      (i_if),
        .d_port      (d_if),
        .mem_req     (mem_req),
        .mem_address (mem_address),
        .mem_ack     (mem_ack),
        .mem_r_data  (mem_r_data),
        .mem_w_data  (mem_w_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        i_if.req = REQ_NONE; i_if.address = '0; i_if.w_data = '0;
        d_if.req = REQ_NONE; d_if.address = '0; d_if.w_data = '0;
        mem_ack = 1'b0; mem_r_data = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b1;
            i_if.req = REQ_READ; d_if.req = REQ_WRITE; d_if.w_data = 16'hFFFF;
            mem_ack = 1'b1; mem_r_data = 16'hFFFF;
            #1;
            n_cmp++; if (mem_req !== REQ_NONE) begin n_bad++; $display("FAIL reset_mem_req: got %0d want 0", mem_req); end
            n_cmp++; if (mem_address !== '0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", mem_address); end
            n_cmp++; if (mem_w_data !== '0) begin n_bad++; $display("FAIL reset_w_data: got %0h want 0", mem_w_data); end
            n_cmp++; if ({i_if.ack, d_if.ack} !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", {i_if.ack, d_if.ack}); end
            n_cmp++; if ({i_if.r_data, d_if.r_data} !== '0) begin n_bad++; $display("FAIL reset_r_data: got %0h/%0h want 0/0", i_if.r_data, d_if.r_data); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        end
        @(negedge clk); rst = 1'b0; idle_inputs(); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_lone_read();
        @(negedge clk); d_if.req = REQ_READ; d_if.address = 10'h3A5; #1;
        n_cmp++; if (mem_req !== REQ_NONE) begin n_bad++; $display("FAIL lone_pre_req: got %0d want 0", mem_req); end
        @(negedge clk); mem_ack = 1'b1; d_if.req = REQ_NONE; mem_r_data = 16'hDEAD; #1;
        n_cmp++; if (mem_req !== REQ_READ) begin n_bad++; $display("FAIL lone_req: got %0d want 1", mem_req); end
        n_cmp++; if (mem_address !== 10'h3A5) begin n_bad++; $display("FAIL lone_addr: got %0h want 3a5", mem_address); end
        n_cmp++; if ({i_if.ack, d_if.ack} !== 2'b01) begin n_bad++; $display("FAIL lone_ack: got %b want 01", {i_if.ack, d_if.ack}); end
        n_cmp++; if (d_if.r_data !== '0) begin n_bad++; $display("FAIL lone_cmd_rdata: got %0h want 0", d_if.r_data); end
        for (int n = 0; n < BEATS; n++) begin
            logic [DW-1:0] w;
            w = 16'(16'h1111 * (n + 1));
            @(negedge clk); mem_ack = 1'b0; mem_r_data = w; #1;
            n_cmp++; if (d_if.r_data !== w) begin n_bad++; $display("FAIL lone_beat%0d: got %0h want %0h", n, d_if.r_data, w); end
            n_cmp++; if ({i_if.ack, d_if.ack, i_if.r_data} !== '0) begin n_bad++; $display("FAIL lone_quiet%0d: got ack %b%b i_rdata %0h want 0", n, i_if.ack, d_if.ack, i_if.r_data); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lone_busy%0d: got %b want 1", n, busy); end
        end
        @(negedge clk); mem_r_data = 16'h7777; #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lone_end_busy: got %b want 0", busy); end
        n_cmp++; if (d_if.r_data !== '0) begin n_bad++; $display("FAIL lone_end_rdata: got %0h want 0", d_if.r_data); end
        idle_inputs();
    endtask

    task automatic test_write_burst();
        @(negedge clk); d_if.req = REQ_WRITE; d_if.address = 10'h010; d_if.w_data = 16'h00FF; #1;
        n_cmp++; if (mem_w_data !== '0) begin n_bad++; $display("FAIL wr_pre_wdata: got %0h want 0", mem_w_data); end
        @(negedge clk); mem_ack = 1'b1; d_if.req = REQ_NONE; #1;
        n_cmp++; if (mem_req !== REQ_WRITE) begin n_bad++; $display("FAIL wr_req: got %0d want 2", mem_req); end
        n_cmp++; if (mem_address !== 10'h010) begin n_bad++; $display("FAIL wr_addr: got %0h want 10", mem_address); end
        n_cmp++; if (mem_w_data !== '0) begin n_bad++; $display("FAIL wr_cmd_wdata: got %0h want 0", mem_w_data); end
        for (int n = 0; n < BEATS; n++) begin
            @(negedge clk); mem_ack = 1'b0; d_if.w_data = 16'(16'hA0 + n); i_if.w_data = 16'h5A5A; #1;
            n_cmp++; if (mem_w_data !== 16'(16'hA0 + n)) begin n_bad++; $display("FAIL wr_beat%0d: got %0h want %0h", n, mem_w_data, 16'hA0 + n); end
            n_cmp++; if (d_if.r_data !== '0) begin n_bad++; $display("FAIL wr_rdata%0d: got %0h want 0", n, d_if.r_data); end
        end
        @(negedge clk); d_if.w_data = 16'h00EE; #1;
        n_cmp++; if (mem_w_data !== '0) begin n_bad++; $display("FAIL wr_post_wdata: got %0h want 0", mem_w_data); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] w;
        apply_reset();
        @(negedge clk); i_if.req = REQ_READ; i_if.address = 10'h111;
        d_if.req = REQ_READ; d_if.address = 10'h222; #1;
        @(negedge clk); mem_ack = 1'b1; d_if.req = REQ_NONE; #1;
        n_cmp++; if (mem_address !== 10'h222) begin n_bad++; $display("FAIL tie1_addr: got %0h want 222", mem_address); end
        n_cmp++; if ({i_if.ack, d_if.ack} !== 2'b01) begin n_bad++; $display("FAIL tie1_ack: got %b want 01", {i_if.ack, d_if.ack}); end
        for (int n = 0; n < BEATS; n++) begin
            w = 16'($urandom);
            @(negedge clk); mem_ack = 1'b0; mem_r_data = w; #1;
            n_cmp++; if (d_if.r_data !== w || i_if.r_data !== '0 || i_if.ack !== 1'b0) begin
                n_bad++; $display("FAIL tie1_beat%0d: got d %0h i %0h iack %b want d %0h i 0 iack 0", n, d_if.r_data, i_if.r_data, i_if.ack, w); end
        end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || mem_req !== REQ_NONE || i_if.ack !== 1'b0) begin
            n_bad++; $display("FAIL tie_turnaround: got busy %b req %0d iack %b want 0 0 0", busy, mem_req, i_if.ack); end
        @(negedge clk); mem_ack = 1'b1; i_if.req = REQ_NONE; d_if.req = REQ_READ; #1;
        n_cmp++; if (mem_address !== 10'h111 || {i_if.ack, d_if.ack} !== 2'b10) begin
            n_bad++; $display("FAIL tie_i_grant: got addr %0h ack %b want 111 10", mem_address, {i_if.ack, d_if.ack}); end
        for (int n = 0; n < BEATS; n++) begin
            w = 16'($urandom);
            @(negedge clk); mem_ack = 1'b0; i_if.req = REQ_READ; mem_r_data = w; #1;
            n_cmp++; if (i_if.r_data !== w || d_if.r_data !== '0) begin
                n_bad++; $display("FAIL tie_i_beat%0d: got i %0h d %0h want %0h 0", n, i_if.r_data, d_if.r_data, w); end
        end
        @(negedge clk); #1;
        @(negedge clk); mem_ack = 1'b1; #1;
        n_cmp++; if (mem_address !== 10'h222 || {i_if.ack, d_if.ack} !== 2'b01) begin
            n_bad++; $display("FAIL tie2_grant: got addr %0h ack %b want 222 01", mem_address, {i_if.ack, d_if.ack}); end
        d_if.req = REQ_NONE; i_if.req = REQ_NONE;
        for (int n = 0; n < BEATS; n++) begin
            @(negedge clk); mem_ack = 1'b0;
        end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tie2_end_busy: got %b want 0", busy); end
        idle_inputs();
    endtask

    task automatic test_delayed_ack();
        @(negedge clk); d_if.req = REQ_READ; d_if.address = 10'h2B7; #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); mem_ack = (c == 3); #1;
            n_cmp++; if (mem_req !== REQ_READ || mem_address !== 10'h2B7) begin
                n_bad++; $display("FAIL dly_cmd%0d: got req %0d addr %0h want 1 2b7", c, mem_req, mem_address); end
            n_cmp++; if (d_if.ack !== 1'(c == 3)) begin n_bad++; $display("FAIL dly_ack%0d: got %b want %b", c, d_if.ack, c == 3); end
        end
        d_if.req = REQ_NONE;
        for (int n = 0; n < BEATS; n++) begin
            @(negedge clk); mem_ack = 1'b0; mem_r_data = 16'(16'hC0 + n); #1;
            n_cmp++; if (d_if.r_data !== 16'(16'hC0 + n)) begin n_bad++; $display("FAIL dly_beat%0d: got %0h want %0h", n, d_if.r_data, 16'hC0 + n); end
        end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dly_end_busy: got %b want 0", busy); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); i_if.req = REQ_WRITE; i_if.address = 10'h0AB; #1;
            n_cmp++; if (busy !== 1'b0 || mem_req !== REQ_NONE) begin
                n_bad++; $display("FAIL iwrite_ignored%0d: got busy %b req %0d want 0 0", c, busy, mem_req); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk); d_if.req = REQ_READ; d_if.address = 10'h0F0; #1;
        @(negedge clk); mem_ack = 1'b1; d_if.req = REQ_NONE; #1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); mem_ack = 1'b0; mem_r_data = 16'(16'hD0 + n); rst = (n == 2); #1;
            n_cmp++; if (d_if.r_data !== 16'(16'hD0 + n)) begin n_bad++; $display("FAIL rstmid_beat%0d: got %0h want %0h", n, d_if.r_data, 16'hD0 + n); end
        end
        @(negedge clk); rst = 1'b0; mem_ack = 1'b1; mem_r_data = 16'hBEEF; #1;
        n_cmp++; if (mem_req !== REQ_NONE || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got req %0d busy %b want 0 0", mem_req, busy); end
        n_cmp++; if ({i_if.ack, d_if.ack} !== 2'b00 || i_if.r_data !== '0 || d_if.r_data !== '0) begin
            n_bad++; $display("FAIL rstmid_outs: got ack %b rdata %0h/%0h want 00 0/0", {i_if.ack, d_if.ack}, i_if.r_data, d_if.r_data); end
        @(negedge clk); mem_ack = 1'b0; i_if.req = REQ_READ; i_if.address = 10'h155; #1;
        @(negedge clk); mem_ack = 1'b1; i_if.req = REQ_NONE; #1;
        n_cmp++; if (mem_address !== 10'h155 || i_if.ack !== 1'b1) begin n_bad++; $display("FAIL rstmid_i_grant: got addr %0h ack %b want 155 1", mem_address, i_if.ack); end
        for (int n = 0; n < BEATS; n++) begin
            @(negedge clk); mem_ack = 1'b0; mem_r_data = 16'(16'hE0 + n); #1;
            n_cmp++; if (i_if.r_data !== 16'(16'hE0 + n)) begin n_bad++; $display("FAIL rstmid_i_beat%0d: got %0h want %0h", n, i_if.r_data, 16'hE0 + n); end
        end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_i_end: got busy %b want 0", busy); end
        idle_inputs();
    endtask

    // Model: each requester is a pending flag; a tie goes to whoever was not
    // served last, and each grant is one command phase plus BEATS data cycles.
    task automatic test_random();
        int model_last;
        model_last = 0;
        apply_reset();
        for (int r = 0; r < 40; r++) begin
            CacheRequest i_op, d_op, exp_op;
            logic [AW-1:0] i_a, d_a, exp_a;
            logic [DW-1:0] rd, wi, wd;
            bit pend_i, pend_d;
            int win, k;
            i_op = CacheRequest'($urandom_range(0, 2));
            d_op = CacheRequest'($urandom_range(0, 2));
            i_a = AW'($urandom); d_a = AW'($urandom);
            pend_i = (i_op == REQ_READ);
            pend_d = (d_op != REQ_NONE);
            @(negedge clk);
            i_if.req = i_op; i_if.address = i_a; d_if.req = d_op; d_if.address = d_a; mem_ack = 1'b0; #1;
            n_cmp++; if (busy !== 1'b0 || mem_req !== REQ_NONE) begin n_bad++; $display("FAIL rnd%0d_start: got busy %b req %0d want 0 0", r, busy, mem_req); end
            while (pend_i || pend_d) begin
                win = (pend_i && pend_d) ? 1 - model_last : (pend_d ? 1 : 0);
                exp_op = (win == 1) ? d_op : REQ_READ;
                exp_a = (win == 1) ? d_a : i_a;
                k = $urandom_range(0, 3);
                for (int c = 0; c <= k; c++) begin
                    @(negedge clk); mem_ack = (c == k); mem_r_data = 16'($urandom);
                    if (c == k && win == 1) d_if.req = REQ_NONE;
                    if (c == k && win == 0) i_if.req = REQ_NONE;
                    #1;
                    n_cmp++; if (mem_req !== exp_op || mem_address !== exp_a) begin
                        n_bad++; $display("FAIL rnd%0d_cmd: got req %0d addr %0h want %0d %0h", r, mem_req, mem_address, exp_op, exp_a); end
                    n_cmp++; if ({i_if.ack, d_if.ack} !== ((c == k) ? ((win == 1) ? 2'b01 : 2'b10) : 2'b00)) begin
                        n_bad++; $display("FAIL rnd%0d_ack: got %b owner %0d cycle %0d of %0d", r, {i_if.ack, d_if.ack}, win, c, k); end
                end
                for (int b = 0; b < BEATS; b++) begin
                    rd = 16'($urandom); wi = 16'($urandom); wd = 16'($urandom);
                    @(negedge clk); mem_ack = 1'b0; mem_r_data = rd; i_if.w_data = wi; d_if.w_data = wd; #1;
                    if (exp_op == REQ_READ) begin
                        n_cmp++; if (((win == 1) ? d_if.r_data : i_if.r_data) !== rd || mem_w_data !== '0) begin
                            n_bad++; $display("FAIL rnd%0d_rd%0d: got i %0h d %0h w %0h want %0h owner %0d", r, b, i_if.r_data, d_if.r_data, mem_w_data, rd, win); end
                    end else begin
                        n_cmp++; if (mem_w_data !== wd || d_if.r_data !== '0) begin
                            n_bad++; $display("FAIL rnd%0d_wr%0d: got w %0h rdata %0h want %0h 0", r, b, mem_w_data, d_if.r_data, wd); end
                    end
                    n_cmp++; if (((win == 1) ? i_if.r_data : d_if.r_data) !== '0 || busy !== 1'b1) begin
                        n_bad++; $display("FAIL rnd%0d_other%0d: got rdata %0h busy %b want 0 1", r, b, (win == 1) ? i_if.r_data : d_if.r_data, busy); end
                end
                if (win == 1) pend_d = 1'b0; else pend_i = 1'b0;
                model_last = win;
                @(negedge clk);
                if (!(pend_i || pend_d)) begin i_if.req = REQ_NONE; d_if.req = REQ_NONE; end
                #1;
                n_cmp++; if (busy !== 1'b0 || mem_req !== REQ_NONE || mem_w_data !== '0) begin
                    n_bad++; $display("FAIL rnd%0d_turn: got busy %b req %0d w %0h want 0 0 0", r, busy, mem_req, mem_w_data); end
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_lone_read();
        test_write_burst();
        test_simultaneous();
        test_delayed_ack();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single backing-memory port between the instruction-cache and data-cache refill/writeback channels. Both caches issue block requests (`REQ_READ` / `REQ_WRITE`) and then stream `BEATS` transfers, one per cycle, starting the cycle after `ack`. The arbiter grants one requester at a time using round-robin priority. It forwards the command to memory and steers the burst data in both directions, so neither cache knows the other exists. It sits between the two caches and the memory model/controller at the top of the pipelined processor.

## Interface
Parameters:
- `ADDR_BITS`, default `16 - $clog2(`CACHE_BLOCK_SIZE)`: block address width.
- `BEATS`, default `` `CACHE_BLOCK_SIZE / `MEM_TRANS_SIZE ``: transfers per block, power of two, ≥2.

Ports:
- `clk`  in  1  single clock, all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `i_port`  `d_cache_request_ifc.memory`  —  instruction-cache channel (`req`, `address`, `w_data` in; `ack`, `r_data` out).
- `d_port`  `d_cache_request_ifc.memory`  —  data-cache channel, same modport.
- `mem_req`  out  `CacheRequest`  command to memory: `REQ_NONE`, `REQ_READ` or `REQ_WRITE`.
- `mem_address`  out  `ADDR_BITS`  block address of the command.
- `mem_ack`  in  1  memory accepts the command; beats follow on the next cycle.
- `mem_r_data`  in  `` `MEM_TRANS_SIZE ``  read beat from memory.
- `mem_w_data`  out  `` `MEM_TRANS_SIZE ``  write beat to memory.
- `busy`  out  1  high whenever the state is not ARB_IDLE.

## Operation
- **States:**
  - ARB_IDLE: no grant held.
    - Pick a winner among active requesters.
    - Register `owner` and the owner's op/address.
    - Go to ARB_CMD.
    - If nobody requests, stay in ARB_IDLE.
  - ARB_CMD:
    - Drive `mem_req` and `mem_address` from the registered values.
    - Pass `mem_ack` combinationally to the owner's `ack`.
    - On `mem_ack`, clear `beat` to 0 and go to ARB_BURST.
  - ARB_BURST:
    - Read: `owner.r_data = mem_r_data`.
    - Write: `mem_w_data = owner.w_data`.
    - `beat` increments each cycle.
    - When `beat == BEATS-1`, go to ARB_IDLE and toggle `last_grant` to the owner.
- **Active request:**
  - `d_port.req != REQ_NONE` counts as a d-cache request.
  - On `i_port`, only `REQ_READ` counts. `REQ_WRITE` on `i_port` is treated as `REQ_NONE` and is never granted.
- **Round robin:**
  - With one active requester, it wins.
  - With both active, the requester that is not `last_grant` wins.
  - `last_grant` resets to OWNER_I, so the d-cache wins the first tie.
- **Locked grant:**
  - The owner's `req` is sampled only in ARB_IDLE.
  - A requester dropping `req` after the grant does not abort the sequence. ARB_CMD and the full burst still complete, and read data is still driven to that port.
- **Non-owner outputs:** `ack = 0` and `r_data = 0` at all times.
- **Idle data outputs:** `mem_w_data = 0` outside a write burst. Owner `r_data = 0` outside a read burst.
- **No stalls:** memory must deliver or accept one beat every ARB_BURST cycle.
- **`beat` width:** `$clog2(BEATS)` bits. It wraps naturally after `BEATS-1`; the state transition, not the wrap, ends the burst.
- **Reset:**
  - State ARB_IDLE, `beat = 0`, `last_grant = OWNER_I`.
  - `mem_req = REQ_NONE`, `mem_address = 0`, `mem_w_data = 0`, both `ack = 0`, both `r_data = 0`, `busy = 0`.
  - Reset in any state, including mid-burst, abandons the transfer immediately. The next cycle is ARB_IDLE.

## Timing
- Request present in ARB_IDLE at cycle T → `mem_req` valid at T+1.
- With `mem_ack` at T+1: owner `ack` = 1 at T+1 (same cycle), beats 0..BEATS-1 at T+2..T+1+BEATS, ARB_IDLE at T+2+BEATS.
- Earliest next `mem_req` is T+3+BEATS: one mandatory idle turnaround cycle.
- `mem_ack` delayed by k cycles delays everything after it by k cycles. `mem_req` stays stable, with unchanged address, until acked.
- Beat n of the burst corresponds to cache data bits `[n*MEM_TRANS_SIZE +: MEM_TRANS_SIZE]`. The arbiter does no reordering.

## Structure
- **Add to `nand_cpu_pkg`:**
  - `MemOwner` enum {OWNER_I, OWNER_D}.
  - `ArbState` enum {ARB_IDLE, ARB_CMD, ARB_BURST}. These names are distinct from the existing global cache states.
- `CacheRequest` is reused unchanged from the package.
- One natural sub-module, `rr_pick2`: combinational 2-way round-robin picker. Inputs: two request bits and `last_grant`. Outputs: a valid bit and the winner.
- Everything else is one module: FSM, `beat` counter, grant registers and data muxes.

## Test plan
Bench configuration: `CACHE_BLOCK_SIZE = 64`, `MEM_TRANS_SIZE = 16` (`BEATS = 4`, `ADDR_BITS = 10`).
- **Lone d-cache read:** `d_port` `REQ_READ` at address `0x3A5`, memory acks at once and returns 0x1111, 0x2222, 0x3333, 0x4444 → `d_port.ack` one cycle at T+1, the same four words on `d_port.r_data` at T+2..T+5, `i_port` outputs stay 0, `busy` falls at T+6.
- **d-cache write burst:** `REQ_WRITE` at `0x010`, cache drives 0xA0..0xA3 → `mem_req = REQ_WRITE`, `mem_address = 0x010`, `mem_w_data` shows 0xA0..0xA3 in order, 0 before and after.
- **Simultaneous requests after reset:** both ports request at the same cycle → d served first. i is granted at T+6 (`mem_req` at T+7) and its `ack` stays 0 until then. A second tie afterwards goes to d.
- **Delayed acknowledge with `REQ_WRITE` on `i_port`:** `mem_ack` held low for 3 cycles → `mem_req` and address stable for 4 cycles and owner `ack` only on the fourth. `REQ_WRITE` on `i_port` alone is never granted (`busy` stays 0).
- **Reset mid-burst:** `rst` asserted during beat 2 of a read → next cycle ARB_IDLE, `mem_req = REQ_NONE`, all `ack` and `r_data` 0. A subsequent `i_port` read completes normally.
